// File: rtl/mmio_io_pkg.sv
// mmio_io_pkg: shared constants for the Otter MMIO hub.
//   - Slot indices. Slot 0 is the switch port, slots 1..N_OUT are the output
//     registers, and the keyboard/VGA slots follow the output block, so they
//     are computed from N_OUT.
//   - KBD_STAT bit positions for read and write.
package mmio_io_pkg;

  localparam int SLOT_SW   = 0;
  localparam int SLOT_OUT0 = 1;

  function automatic int slot_kbd_data(input int n_out);
    return n_out + 1;
  endfunction

  function automatic int slot_kbd_stat(input int n_out);
    return n_out + 2;
  endfunction

  function automatic int slot_vga_addr(input int n_out);
    return n_out + 3;
  endfunction

  function automatic int slot_vga_color(input int n_out);
    return n_out + 4;
  endfunction

  function automatic int slot_vga_read(input int n_out);
    return n_out + 5;
  endfunction

  // Total number of decoded slots.
  function automatic int num_slots(input int n_out);
    return n_out + 6;
  endfunction

  // KBD_STAT read layout
  localparam int STAT_NONEMPTY_BIT = 0;
  localparam int STAT_OVF_BIT      = 1;
  localparam int STAT_IE_BIT       = 2;
  localparam int STAT_COUNT_LSB    = 8;

  // KBD_STAT write layout
  localparam int STAT_WR_OVF_CLR_BIT = 0;
  localparam int STAT_WR_IE_BIT      = 1;

endpackage

// File: rtl/mmio_io_hub_if.sv
// mmio_io_hub_if: Otter IOBUS bundle.
//   IOBUS_ADDR  bus address        (CPU -> hub)
//   IOBUS_OUT   CPU write data     (CPU -> hub)
//   IOBUS_WR    store strobe       (CPU -> hub)
//   IOBUS_RD    load strobe        (CPU -> hub)
//   IOBUS_IN    read data          (hub -> CPU, combinational)
interface mmio_io_hub_if;
  logic [31:0] IOBUS_ADDR;
  logic [31:0] IOBUS_OUT;
  logic        IOBUS_WR;
  logic        IOBUS_RD;
  logic [31:0] IOBUS_IN;

  modport master (
    output IOBUS_ADDR, IOBUS_OUT, IOBUS_WR, IOBUS_RD,
    input  IOBUS_IN
  );

  modport slave (
    input  IOBUS_ADDR, IOBUS_OUT, IOBUS_WR, IOBUS_RD,
    output IOBUS_IN
  );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with a sticky overflow flag.
//   CLK, RST          clock, asynchronous active-high reset
//   i_push, i_data    push strobe and data
//   i_pop             pop strobe (ignored while empty)
//   i_ovf_clr         clears the overflow flag
//   o_head            oldest entry (combinational read)
//   o_empty           FIFO holds no entries
//   o_nonempty_next   FIFO will be non-empty after this edge
//   o_count           number of entries, 0..DEPTH
//   o_ovf             a push was dropped because the FIFO was full
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  input  logic                     i_ovf_clr,
  output logic [WIDTH-1:0]         o_head,
  output logic                     o_empty,
  output logic                     o_nonempty_next,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_ovf
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_next;
  logic             r_ovf;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;

  assign o_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_pop   = i_pop & ~o_empty;
  // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
  assign w_push  = i_push & (~w_full | w_pop);
  assign w_drop  = i_push & w_full & ~w_pop;

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + CW'(1);
    end else if (w_pop && !w_push) begin
      w_count_next = r_count - CW'(1);
    end
  end

  // Storage has no reset so it maps onto plain RAM; pointers define validity.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // DEPTH is a power of two, so pointer wrap is natural binary rollover.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= w_count_next;
      // A fresh drop in the same cycle as a clear leaves the flag set.
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (i_ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign o_head          = r_mem[r_rd_ptr];
  assign o_nonempty_next = (w_count_next != '0);
  assign o_count         = r_count;
  assign o_ovf           = r_ovf;
endmodule

// File: rtl/mmio_io_hub.sv
// mmio_io_hub: memory-mapped I/O hub on the Otter IOBUS.
//   CLK, RST     50 MHz CPU clock, asynchronous active-high reset
//   bus          IOBUS slave (address, write data, strobes, read data)
//   SWITCHES     board switch input, read at slot 0
//   OUT_PORTS    N_OUT output registers, port k at [k*OUT_W +: OUT_W]
//   KBD_VALID    one-cycle strobe qualifying KBD_CODE
//   KBD_CODE     keyboard scancode, buffered in a FIFO
//   INTR         registered ie & FIFO non-empty
//   VGA_WA/WD    framebuffer write address/data, held until rewritten
//   VGA_WE       one-cycle pulse after each VGA_COLOR write
//   VGA_RD       framebuffer read data, read at VGA_READ
module mmio_io_hub
  import mmio_io_pkg::*;
#(
  parameter logic [31:0] BASE_AD    = 32'h1100_0000,
  parameter logic [31:0] STRIDE     = 32'h20,
  parameter int          N_OUT      = 4,
  parameter int          OUT_W      = 16,
  parameter int          IN_W       = 16,
  parameter int          FIFO_DEPTH = 8,
  parameter int          VGA_AW     = 13
) (
  input  logic                   CLK,
  input  logic                   RST,
  mmio_io_hub_if.slave           bus,
  input  logic [IN_W-1:0]        SWITCHES,
  output logic [N_OUT*OUT_W-1:0] OUT_PORTS,
  input  logic                   KBD_VALID,
  input  logic [7:0]             KBD_CODE,
  output logic                   INTR,
  output logic [VGA_AW-1:0]      VGA_WA,
  output logic [7:0]             VGA_WD,
  output logic                   VGA_WE,
  input  logic [7:0]             VGA_RD
);
  localparam int NSLOT   = num_slots(N_OUT);
  localparam int S_KDATA = slot_kbd_data(N_OUT);
  localparam int S_KSTAT = slot_kbd_stat(N_OUT);
  localparam int S_VADDR = slot_vga_addr(N_OUT);
  localparam int S_VCOL  = slot_vga_color(N_OUT);
  localparam int S_VREAD = slot_vga_read(N_OUT);
  localparam int CW      = $clog2(FIFO_DEPTH) + 1;

  logic [NSLOT-1:0]       w_hit;
  logic [N_OUT*OUT_W-1:0] w_out_flat;
  logic [31:0]            w_out_rd [N_OUT+1];
  logic [31:0]            w_rdata;
  logic                   w_kbd_pop;
  logic                   w_ovf_clr;
  logic                   w_stat_wr;
  logic                   w_ie_next;
  logic [7:0]             w_head;
  logic                   w_empty;
  logic                   w_nonempty_next;
  logic [CW-1:0]          w_count;
  logic                   w_ovf;
  logic                   r_ie;
  logic                   r_intr;
  logic [VGA_AW-1:0]      r_vga_wa;
  logic [7:0]             r_vga_wd;
  logic                   r_vga_we;
  logic                   w_unused;

  // Exact-match decode: one comparator per slot, everything else misses.
  for (genvar gi = 0; gi < NSLOT; gi++) begin : g_dec
    assign w_hit[gi] = (bus.IOBUS_ADDR == BASE_AD + STRIDE * 32'(gi));
  end

  // Output registers, plus an OR chain building their readback word.
  assign w_out_rd[0] = '0;
  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_out
    logic [OUT_W-1:0] r_out;
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        r_out <= '0;
      end else if (bus.IOBUS_WR && w_hit[SLOT_OUT0+gi]) begin
        r_out <= bus.IOBUS_OUT[OUT_W-1:0];
      end
    end
    assign w_out_flat[gi*OUT_W +: OUT_W] = r_out;
    assign w_out_rd[gi+1] = w_out_rd[gi] | (w_hit[SLOT_OUT0+gi] ? 32'(r_out) : 32'd0);
  end
  assign OUT_PORTS = w_out_flat;

  // Keyboard FIFO. Writes to KBD_DATA are ignored; only loads pop.
  assign w_kbd_pop = bus.IOBUS_RD & w_hit[S_KDATA];
  assign w_stat_wr = bus.IOBUS_WR & w_hit[S_KSTAT];
  assign w_ovf_clr = w_stat_wr & bus.IOBUS_OUT[STAT_WR_OVF_CLR_BIT];
  assign w_ie_next = w_stat_wr ? bus.IOBUS_OUT[STAT_WR_IE_BIT] : r_ie;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_kbd_fifo (
    .CLK             (CLK),
    .RST             (RST),
    .i_push          (KBD_VALID),
    .i_data          (KBD_CODE),
    .i_pop           (w_kbd_pop),
    .i_ovf_clr       (w_ovf_clr),
    .o_head          (w_head),
    .o_empty         (w_empty),
    .o_nonempty_next (w_nonempty_next),
    .o_count         (w_count),
    .o_ovf           (w_ovf)
  );

  // INTR is computed from next-state values so it is a true flop output that
  // tracks ie & nonempty with no extra cycle of lag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ie     <= 1'b0;
      r_intr   <= 1'b0;
      r_vga_wa <= '0;
      r_vga_wd <= '0;
      r_vga_we <= 1'b0;
    end else begin
      r_ie     <= w_ie_next;
      r_intr   <= w_ie_next & w_nonempty_next;
      r_vga_we <= bus.IOBUS_WR & w_hit[S_VCOL];
      if (bus.IOBUS_WR && w_hit[S_VADDR]) r_vga_wa <= bus.IOBUS_OUT[VGA_AW-1:0];
      if (bus.IOBUS_WR && w_hit[S_VCOL])  r_vga_wd <= bus.IOBUS_OUT[7:0];
    end
  end

  // Read mux; write-only slots and unmapped addresses read 0.
  always_comb begin
    w_rdata = w_out_rd[N_OUT];
    if (w_hit[SLOT_SW]) w_rdata = 32'(SWITCHES);
    if (w_hit[S_KDATA] && !w_empty) w_rdata = {23'b0, 1'b1, w_head};
    if (w_hit[S_KSTAT]) begin
      w_rdata = '0;
      w_rdata[STAT_COUNT_LSB +: 8]  = 8'(w_count);
      w_rdata[STAT_IE_BIT]          = r_ie;
      w_rdata[STAT_OVF_BIT]         = w_ovf;
      w_rdata[STAT_NONEMPTY_BIT]    = ~w_empty;
    end
    if (w_hit[S_VREAD]) w_rdata = {24'b0, VGA_RD};
  end

  assign bus.IOBUS_IN = w_rdata;
  assign INTR         = r_intr;
  assign VGA_WA       = r_vga_wa;
  assign VGA_WD       = r_vga_wd;
  assign VGA_WE       = r_vga_we;

  // Upper write-data bits are don't-care for every slot.
  assign w_unused = ^bus.IOBUS_OUT;
endmodule

// File: tb/tb_mmio_io_hub.sv
module tb_mmio_io_hub;
  localparam logic [31:0] BASE   = 32'h1100_0000;
  localparam logic [31:0] STRIDE = 32'h20;
  localparam int          DEPTH  = 8;
  // Slot numbers for the default N_OUT = 4 map.
  localparam int SL_SW = 0, SL_KD = 5, SL_KS = 6, SL_VA = 7, SL_VC = 8, SL_VR = 9;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] SWITCHES = '0;
  logic [63:0] OUT_PORTS;
  logic        KBD_VALID = 1'b0;
  logic [7:0]  KBD_CODE = '0;
  logic        INTR;
  logic [12:0] VGA_WA;
  logic [7:0]  VGA_WD;
  logic        VGA_WE;
  logic [7:0]  VGA_RD = '0;

  always #5 CLK = ~CLK;

  mmio_io_hub_if bus ();

  mmio_io_hub dut (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (bus),
    .SWITCHES  (SWITCHES),
    .OUT_PORTS (OUT_PORTS),
    .KBD_VALID (KBD_VALID),
    .KBD_CODE  (KBD_CODE),
    .INTR      (INTR),
    .VGA_WA    (VGA_WA),
    .VGA_WD    (VGA_WD),
    .VGA_WE    (VGA_WE),
    .VGA_RD    (VGA_RD)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] m_out [4];
  bit   [7:0]  m_kq [$];
  bit          m_ie, m_ovf, m_we;
  logic [12:0] m_wa;
  logic [7:0]  m_wd;

  typedef struct {
    logic        intr;
    logic [63:0] outp;
    logic        we;
    logic [12:0] wa;
    logic [7:0]  wd;
  } st_t;

  st_t         st_q [$];
  logic [31:0] rd_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  function automatic logic [31:0] addr_of(input int s);
    return BASE + STRIDE * 32'(s);
  endfunction

  function automatic int slot_of(input logic [31:0] a);
    logic [31:0] off;
    if (a < BASE) return -1;
    off = a - BASE;
    if (off % STRIDE != 0) return -1;
    if (off / STRIDE >= 10) return -1;
    return int'(off / STRIDE);
  endfunction

  function automatic logic [31:0] model_read(input int s);
    logic [31:0] r;
    r = '0;
    if (s == SL_SW) r = {16'b0, SWITCHES};
    else if (s >= 1 && s <= 4) r = {16'b0, m_out[s-1]};
    else if (s == SL_KD) r = (m_kq.size() > 0) ? (32'h100 | 32'(m_kq[0])) : 32'h0;
    else if (s == SL_KS) r = (32'(m_kq.size()) << 8) | (32'(m_ie) << 2) | (32'(m_ovf) << 1)
                             | 32'(m_kq.size() > 0);
    else if (s == SL_VR) r = {24'b0, VGA_RD};
    return r;
  endfunction

  function automatic st_t model_status();
    st_t st;
    st.intr = m_ie && (m_kq.size() > 0);
    st.outp = {m_out[3], m_out[2], m_out[1], m_out[0]};
    st.we   = m_we;
    st.wa   = m_wa;
    st.wd   = m_wd;
    return st;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_out[i] = '0;
    m_kq.delete();
    m_ie = 0; m_ovf = 0; m_we = 0; m_wa = '0; m_wd = '0;
  endtask

  // One bus cycle. Called just after a rising edge; returns just after the next.
  task automatic cycle(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d,
                       input bit kv, input logic [7:0] kc);
    int  s;
    bit  pop;
    bus.IOBUS_ADDR = a;
    bus.IOBUS_OUT  = d;
    bus.IOBUS_WR   = wr;
    bus.IOBUS_RD   = rd;
    KBD_VALID      = kv;
    KBD_CODE       = kc;
    s = slot_of(a);
    if (rd) rd_q.push_back(model_read(s));
    m_we = 0;
    if (wr) begin
      if (s >= 1 && s <= 4) m_out[s-1] = d[15:0];
      if (s == SL_KS) begin
        m_ie = d[1];
        if (d[0]) m_ovf = 0;
      end
      if (s == SL_VA) m_wa = d[12:0];
      if (s == SL_VC) begin
        m_wd = d[7:0];
        m_we = 1;
      end
    end
    pop = rd && (s == SL_KD) && (m_kq.size() > 0);
    if (pop) void'(m_kq.pop_front());
    if (kv) begin
      if (m_kq.size() == DEPTH) m_ovf = 1;
      else m_kq.push_back(kc);
    end
    @(posedge CLK);
    #1;
    st_q.push_back(model_status());
    bus.IOBUS_WR = 0;
    bus.IOBUS_RD = 0;
    KBD_VALID    = 0;
  endtask

  task automatic wr_slot(input int s, input logic [31:0] d);
    cycle(1, 0, addr_of(s), d, 0, 8'h00);
  endtask

  task automatic rd_slot(input int s);
    cycle(0, 1, addr_of(s), 32'h0, 0, 8'h00);
  endtask

  task automatic push(input logic [7:0] c);
    cycle(0, 0, 32'h0, 32'h0, 1, c);
  endtask

  task automatic idle();
    cycle(0, 0, 32'h0, 32'h0, 0, 8'h00);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_out_ports"}, OUT_PORTS, 64'h0);
    chk({tag, "_intr"}, INTR, 0);
    chk({tag, "_vga_we"}, VGA_WE, 0);
    chk({tag, "_vga_wa"}, VGA_WA, 0);
    chk({tag, "_vga_wd"}, VGA_WD, 0);
  endtask

  // Called just after a rising edge: asserts RST between edges, after the
  // monitor has sampled the current cycle.
  task automatic async_reset();
    #5;
    RST = 1'b1;
    #1;
    chk_outputs_zero("async_rst");
    model_reset();
    @(posedge CLK);
    #3;
    RST = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  // Monitor: compares read data whenever a load is presented, and the
  // registered outputs once per cycle against the queued model state.
  always @(negedge CLK) begin
    if (!RST) begin
      if (bus.IOBUS_RD) begin
        if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
        else chk("iobus_in", bus.IOBUS_IN, rd_q.pop_front());
      end
      if (st_q.size() > 0) begin
        st_t e;
        e = st_q.pop_front();
        chk("intr", INTR, e.intr);
        chk("out_ports", OUT_PORTS, e.outp);
        chk("vga_we", VGA_WE, e.we);
        chk("vga_wa", VGA_WA, e.wa);
        chk("vga_wd", VGA_WD, e.wd);
      end
    end
  end

  function automatic logic [31:0] bad_addr();
    case ($urandom_range(0, 3))
      0: return BASE + STRIDE * 10;
      1: return BASE + 32'h4;
      2: return BASE - STRIDE;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    int          op, s;
    logic [31:0] a, d;
    bit          wr, rd, kv;

    bus.IOBUS_ADDR = '0;
    bus.IOBUS_OUT  = '0;
    bus.IOBUS_WR   = 0;
    bus.IOBUS_RD   = 0;
    model_reset();

    #22;
    chk_outputs_zero("reset");
    RST = 1'b0;
    @(posedge CLK);
    #1;

    // Output ports and switches
    SWITCHES = 16'h00F0;
    wr_slot(1, 32'h0000_ABCD);
    cycle(1, 0, BASE + 32'h80, 32'h1234, 0, 8'h00);
    chk("out0_direct", OUT_PORTS[15:0], 16'hABCD);
    chk("out3_direct", OUT_PORTS[63:48], 16'h1234);
    rd_slot(1);
    rd_slot(4);
    rd_slot(SL_SW);

    // Keyboard FIFO with interrupt
    wr_slot(SL_KS, 32'h2);
    push(8'h1C);
    chk("intr_after_push", INTR, 1);
    push(8'h32);
    rd_slot(SL_KS);
    rd_slot(SL_KD);
    rd_slot(SL_KD);
    chk("intr_after_drain", INTR, 0);
    rd_slot(SL_KD);

    // Overflow: nine pushes into eight entries
    for (int i = 0; i < 9; i++) push(8'(8'h40 + i));
    rd_slot(SL_KS);
    wr_slot(SL_KS, 32'h3);
    rd_slot(SL_KS);

    // Full FIFO with simultaneous push and pop, then drain
    cycle(0, 1, addr_of(SL_KD), 32'h0, 1, 8'hA7);
    rd_slot(SL_KS);
    for (int i = 0; i < 9; i++) rd_slot(SL_KD);

    // VGA back-to-back color writes
    wr_slot(SL_VA, 32'h0000_0A5F);
    wr_slot(SL_VC, 32'h0000_00E0);
    wr_slot(SL_VC, 32'h0000_001C);
    idle();
    idle();
    rd_slot(SL_VA);
    VGA_RD = 8'h5A;
    rd_slot(SL_VR);

    // Reset mid-fill and during a VGA_WE pulse
    wr_slot(SL_KS, 32'h2);
    wr_slot(2, 32'hBEEF);
    push(8'h11);
    push(8'h22);
    wr_slot(SL_VC, 32'h77);
    async_reset();
    rd_slot(SL_KS);
    chk("intr_post_reset", INTR, 0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 9);
      s  = $urandom_range(0, 10);
      a  = (s == 10) ? bad_addr() : addr_of(s);
      d  = $urandom();
      wr = (op < 3) || (op == 8);
      rd = (op >= 3 && op < 7) || (op == 8);
      if (op == 6) a = addr_of(SL_KD);
      kv = ($urandom_range(0, 99) < ((n < 200) ? 60 : 25));
      if (wr && slot_of(a) == SL_KS) kv = 0;
      SWITCHES = 16'($urandom());
      VGA_RD   = 8'($urandom());
      cycle(wr, rd, a, d, kv, 8'($urandom()));
    end

    idle();
    @(negedge CLK);
    #1;
    chk("rd_q_drained", rd_q.size(), 0);
    chk("st_q_drained", st_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
